reset_sequencer: RTL and testbench
==================================

# reset_sequencer

Power-on and lock-loss reset sequencer sitting directly downstream of the clock generator. Synchronizes the generator's combined `clkLocked` status into the system clock domain, requires it to be continuously stable for a programmable period, then releases a set of active-low reset stages one by one in a fixed order: fabric, VGA pipeline, SDRAM controller. Any loss of lock re-asserts every stage at once and restarts the sequence.

## Interface
- `STABLE_CYCLES`, default 1024: consecutive synchronized-lock cycles required before release begins (≥2).
- `STAGE_GAP`, default 16: cycles between successive stage releases (≥1).
- `NUM_STAGES`, default 3: number of reset outputs (1..8); stage 0 is released first.
- `SYNC_STAGES`, default 2: flops in the `clkLocked` synchronizer (≥2).
- `clk` input 1: system clock (DCM CLK0 output); all logic is on its rising edge.
- `rstN` input 1: reset, synchronous, active-low.
- `clkLocked` input 1: combined DCM lock status; asynchronous to `clk`.
- `rstStageN` output NUM_STAGES: per-stage reset, active-low; bit i is released i-th.
- `ready` output 1: high once every stage is released.
- `lockLost` output 1: one-cycle pulse when lock drops during RELEASE or RUN.
- `lockLossCount` output 8: saturating count of `lockLost` pulses.

## Operation
- `clkLocked` passes through a SYNC_STAGES flop chain; the last flop is `lockSync`. Nothing else samples `clkLocked`.
- FSM states:
  - HOLD: all stages asserted, `ready`=0. Moves to STABLE when `lockSync`=1.
  - STABLE: counter `stableCnt` runs from 0 up to STABLE_CYCLES-1. If `lockSync`=0, return to HOLD and clear `stableCnt`; this does not count as a loss. When `stableCnt`=STABLE_CYCLES-1 and lock is still high, move to RELEASE.
  - RELEASE: stage index `stg` starts at 0. On entry, deassert `rstStageN[0]`. Every STAGE_GAP cycles, deassert the next stage. STAGE_GAP cycles after the last stage is released, move to RUN.
  - RUN: `ready`=1. Stays here while `lockSync`=1.
- Lock loss: `lockSync`=0 while in RELEASE or RUN.
  - Next cycle: all `rstStageN`=0, `ready`=0, `lockLost`=1 for exactly one cycle, counter incremented, state HOLD.
  - `lockLossCount` saturates at 255 and never wraps.
- Once a stage is released, it is never re-asserted individually. The only way back to reset is a lock loss or `rstN`.
- Counter widths are sized with `$clog2(STABLE_CYCLES)` and `$clog2(STAGE_GAP)`. Counters never exceed their terminal value.

## Timing
- Reset values, applied on the first edge with `rstN`=0:
  - `rstStageN`=0 on all bits, `ready`=0, `lockLost`=0, `lockLossCount`=0.
  - State HOLD, all counters 0, synchronizer flops 0.
- `rstN`=0 takes priority over every other event, in any state.
- Latency from `clkLocked` first sampled high at edge E:
  - `rstStageN[0]` rises at E + SYNC_STAGES + STABLE_CYCLES.
  - `rstStageN[i]` rises i·STAGE_GAP cycles after that.
  - `ready` rises NUM_STAGES·STAGE_GAP cycles after `rstStageN[0]`.
- Latency from `clkLocked` first sampled low to `rstStageN`=0: SYNC_STAGES + 1 cycles.
- A lock drop and a scheduled stage release in the same cycle: the drop wins, and no release occurs.
- A lock glitch shorter than one `clk` period may be missed. This is acceptable.
- All outputs are registered; there is no combinational path from input to output.

## Configuration
- `RESET_SEQ_LOSS_COUNT_EN`:
  - Defined: `lockLossCount` implemented as specified.
  - Undefined: counter logic is omitted and `lockLossCount` is tied to 0. `lockLost` is still generated.

## Structure
- Shared package `reset_seq_pkg`:
  - FSM state encoding (HOLD=0, STABLE=1, RELEASE=2, RUN=3).
  - Default parameter constants.
  - `LOSS_CNT_W`=8.
- Sub-module `lock_sync`: parameterized SYNC_STAGES flop chain with synchronous active-low clear. It is reused by other clock-domain status inputs.
- Everything else stays in `reset_sequencer`.

## Test plan
All scenarios use STABLE_CYCLES=8, STAGE_GAP=4, NUM_STAGES=3, SYNC_STAGES=2.
- Power-up: `rstN` low for 3 cycles, then high; `clkLocked` rises at cycle 0 → `rstStageN` bit 0 rises at 10, bit 1 at 14, bit 2 at 18; `ready`=1 at 22; `lockLossCount`=0.
- Flaky lock in STABLE: `clkLocked` high 5 cycles, low 1 cycle, then high → no outputs change, `lockLost` never pulses, and the release schedule restarts from the second rise.
- Loss in RUN: drop `clkLocked` at cycle 40 → at 43 all `rstStageN`=0, `ready`=0, `lockLost` pulses once, `lockLossCount`=1; re-rise yields the full sequence again.
- Loss mid-RELEASE: drop lock one cycle after bit 1 is released → all bits return to 0 and bit 2 never rises.
- Saturation: force 260 RUN losses → `lockLossCount`=255; with the macro undefined → it stays 0.
- `rstN` asserted in RUN → next edge all outputs are at reset values, even though `clkLocked`=1.

Source files
------------

// File: rtl/reset_seq_pkg.sv
// Shared definitions for the reset sequencer: FSM state encoding, default
// parameter values, loss-counter width and a counter-width helper.
package reset_seq_pkg;

    // Sequencer FSM states, encoding fixed so state dumps are readable.
    typedef enum logic [1:0] {
        HOLD    = 2'd0,
        STABLE  = 2'd1,
        RELEASE = 2'd2,
        RUN     = 2'd3
    } seq_state_e;

    // Default build parameters.
    localparam int DEFAULT_STABLE_CYCLES = 1024;
    localparam int DEFAULT_STAGE_GAP     = 16;
    localparam int DEFAULT_NUM_STAGES    = 3;
    localparam int DEFAULT_SYNC_STAGES   = 2;

    // Lock-loss counter width and its saturation value.
    localparam int                    LOSS_CNT_W   = 8;
    localparam logic [LOSS_CNT_W-1:0] LOSS_CNT_MAX = '1;

    // Width of a counter that runs 0..n-1. Never returns 0, so a
    // degenerate count of 1 still gets a legal one-bit register.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/reset_sequencer_if.sv
// Status/reset bundle between the clock generator, the reset sequencer and
// the blocks it holds in reset. The sequencer takes the master modport; the
// clock generator / reset consumers see the slave side.
interface reset_sequencer_if #(
    parameter int NUM_STAGES = reset_seq_pkg::DEFAULT_NUM_STAGES
);
    import reset_seq_pkg::*;

    logic                  clkLocked;      // raw DCM lock, asynchronous to clk
    logic [NUM_STAGES-1:0] rstStageN;      // per-stage active-low resets
    logic                  ready;          // every stage released
    logic                  lockLost;       // one-cycle pulse on lock loss
    logic [LOSS_CNT_W-1:0] lockLossCount;  // saturating count of lockLost

    modport master (
        input  clkLocked,
        output rstStageN,
        output ready,
        output lockLost,
        output lockLossCount
    );

    modport slave (
        output clkLocked,
        input  rstStageN,
        input  ready,
        input  lockLost,
        input  lockLossCount
    );

endinterface

// File: rtl/lock_sync.sv
// Multi-flop synchronizer for a slow status level crossing into clk.
// The chain is cleared synchronously by rstN so a reset also forgets any
// stale status; reused for other asynchronous status inputs.
module lock_sync #(
    parameter int STAGES = reset_seq_pkg::DEFAULT_SYNC_STAGES  // >= 2
) (
    input  logic clk,
    input  logic rstN,
    input  logic async_i,
    output logic sync_o
);

    logic [STAGES-1:0] chain_q;

    // Shift the asynchronous level through the flop chain.
    always_ff @(posedge clk) begin
        if (!rstN) begin
            chain_q <= '0;
        end else begin
            chain_q <= {chain_q[STAGES-2:0], async_i};
        end
    end

    assign sync_o = chain_q[STAGES-1];

endmodule

// File: rtl/reset_sequencer.sv
// Power-on / lock-loss reset sequencer.
// Waits for the synchronized DCM lock to stay high for STABLE_CYCLES, then
// releases the active-low reset stages in order, one every STAGE_GAP cycles,
// and raises ready STAGE_GAP cycles after the last one. A lock drop while
// releasing or running is confirmed for one cycle (all sequencing frozen),
// then every stage is re-asserted together and lockLost pulses.
// Optional feature macro: RESET_SEQ_LOSS_COUNT_EN enables lockLossCount;
// without it the count output is tied to zero.
module reset_sequencer
    import reset_seq_pkg::*;
#(
    parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES,  // >= 2
    parameter int STAGE_GAP     = DEFAULT_STAGE_GAP,      // >= 1
    parameter int NUM_STAGES    = DEFAULT_NUM_STAGES,     // 1..8
    parameter int SYNC_STAGES   = DEFAULT_SYNC_STAGES     // >= 2
) (
    input  logic               clk,
    input  logic               rstN,
    reset_sequencer_if.master  bus
);

    localparam int STABLE_W = cnt_width(STABLE_CYCLES);
    localparam int GAP_W    = cnt_width(STAGE_GAP);
    localparam int STG_W    = cnt_width(NUM_STAGES);

    localparam logic [STABLE_W-1:0] STABLE_LAST = STABLE_W'(STABLE_CYCLES - 1);
    localparam logic [GAP_W-1:0]    GAP_LAST    = GAP_W'(STAGE_GAP - 1);
    localparam logic [STG_W-1:0]    STG_LAST    = STG_W'(NUM_STAGES - 1);

    logic                  lockSync;
    seq_state_e            state_q;
    logic [STABLE_W-1:0]   stableCnt_q;
    logic [GAP_W-1:0]      gapCnt_q;
    logic [STG_W-1:0]      stg_q;
    logic [NUM_STAGES-1:0] stageN_q;
    logic [NUM_STAGES-1:0] stageShift;
    logic                  ready_q;
    logic                  lockLost_q;
    logic                  lossPend_q;

    // The only sampling point of the asynchronous lock input.
    lock_sync #(
        .STAGES (SYNC_STAGES)
    ) u_lock_sync (
        .clk     (clk),
        .rstN    (rstN),
        .async_i (bus.clkLocked),
        .sync_o  (lockSync)
    );

    // Stages release strictly in order, so releasing the next one is a
    // shift of a 1 into the bottom of the released mask.
    generate
        for (genvar gi = 0; gi < NUM_STAGES; gi++) begin : g_stage_shift
            if (gi == 0) begin : g_first
                assign stageShift[gi] = 1'b1;
            end else begin : g_next
                assign stageShift[gi] = stageN_q[gi-1];
            end
        end
    endgenerate

    // Sequencer FSM with registered outputs. A detected loss sets lossPend_q
    // and freezes the release schedule; the following edge commits the loss.
    always_ff @(posedge clk) begin
        if (!rstN) begin
            state_q     <= HOLD;
            stableCnt_q <= '0;
            gapCnt_q    <= '0;
            stg_q       <= '0;
            stageN_q    <= '0;
            ready_q     <= 1'b0;
            lockLost_q  <= 1'b0;
            lossPend_q  <= 1'b0;
        end else begin
            lockLost_q <= 1'b0;
            if (lossPend_q) begin
                // Commit the loss: everything back to reset at once.
                state_q     <= HOLD;
                stableCnt_q <= '0;
                gapCnt_q    <= '0;
                stg_q       <= '0;
                stageN_q    <= '0;
                ready_q     <= 1'b0;
                lockLost_q  <= 1'b1;
                lossPend_q  <= 1'b0;
            end else begin
                case (state_q)
                    HOLD: begin
                        stableCnt_q <= '0;
                        if (lockSync) begin
                            state_q <= STABLE;
                        end
                    end
                    STABLE: begin
                        if (!lockSync) begin
                            // Lock not yet trusted: quietly start over.
                            state_q     <= HOLD;
                            stableCnt_q <= '0;
                        end else if (stableCnt_q == STABLE_LAST) begin
                            state_q     <= RELEASE;
                            stableCnt_q <= '0;
                            gapCnt_q    <= '0;
                            stg_q       <= '0;
                            stageN_q    <= stageShift;
                        end else begin
                            stableCnt_q <= stableCnt_q + 1'b1;
                        end
                    end
                    RELEASE: begin
                        if (!lockSync) begin
                            // Freezing here is what stops a release that is
                            // due in the same cycle as the drop.
                            lossPend_q <= 1'b1;
                        end else if (gapCnt_q == GAP_LAST) begin
                            gapCnt_q <= '0;
                            if (stg_q == STG_LAST) begin
                                state_q <= RUN;
                                ready_q <= 1'b1;
                            end else begin
                                stg_q    <= stg_q + 1'b1;
                                stageN_q <= stageShift;
                            end
                        end else begin
                            gapCnt_q <= gapCnt_q + 1'b1;
                        end
                    end
                    RUN: begin
                        if (!lockSync) begin
                            lossPend_q <= 1'b1;
                        end
                    end
                    default: begin
                        state_q <= HOLD;
                    end
                endcase
            end
        end
    end

    assign bus.rstStageN = stageN_q;
    assign bus.ready     = ready_q;
    assign bus.lockLost  = lockLost_q;

`ifdef RESET_SEQ_LOSS_COUNT_EN
    logic [LOSS_CNT_W-1:0] lossCnt_q;
    logic [LOSS_CNT_W-1:0] lossCnt_d;

    // Saturating increment, stepping in the same edge lockLost rises.
    always_comb begin
        lossCnt_d = lossCnt_q;
        if (lossPend_q && (lossCnt_q != LOSS_CNT_MAX)) begin
            lossCnt_d = lossCnt_q + 1'b1;
        end
    end

    // Loss counter register.
    always_ff @(posedge clk) begin
        if (!rstN) begin
            lossCnt_q <= '0;
        end else begin
            lossCnt_q <= lossCnt_d;
        end
    end

    assign bus.lockLossCount = lossCnt_q;
`else
    assign bus.lockLossCount = '0;
`endif

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer (STABLE_CYCLES=8, STAGE_GAP=4,
// NUM_STAGES=3, SYNC_STAGES=2). Cycle n is the n-th clock edge counted
// from the first edge that samples the scenario's initial clkLocked value.
module tb_reset_sequencer;

    import reset_seq_pkg::*;

`ifdef RESET_SEQ_LOSS_COUNT_EN
    localparam int CNT_EN = 1;
`else
    localparam int CNT_EN = 0;
`endif

    typedef struct {
        int         cyc;    // edge at which lock is sampled and outputs checked
        logic       lock;   // clkLocked value sampled at that edge (and held)
        logic [2:0] stg;    // expected rstStageN after the edge
        logic       rdy;    // expected ready
        logic       lost;   // expected lockLost
        int         cnt;    // expected loss count when the counter is enabled
    } vec_t;

    logic clk;
    logic rstN;
    int   tests;
    int   fails;
    int   cur;
    vec_t vecs[$];

    reset_sequencer_if #(.NUM_STAGES(3)) bus ();

    reset_sequencer #(
        .STABLE_CYCLES (8),
        .STAGE_GAP     (4),
        .NUM_STAGES    (3),
        .SYNC_STAGES   (2)
    ) dut (
        .clk  (clk),
        .rstN (rstN),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end else begin
            $display("[TB] ok %s = %0h", name, act);
        end
    endtask

    task automatic step1();
        @(posedge clk);
        #1;
        cur++;
    endtask

    function automatic int exp_cnt(input int n);
        return (CNT_EN != 0) ? ((n > 255) ? 255 : n) : 0;
    endfunction

    function automatic void add(input int c, input logic l, input logic [2:0] s,
                                input logic r, input logic lo, input int n);
        vec_t v;
        v.cyc = c; v.lock = l; v.stg = s; v.rdy = r; v.lost = lo; v.cnt = n;
        vecs.push_back(v);
    endfunction

    task automatic run_vecs(input string tag);
        foreach (vecs[i]) begin
            while (cur < vecs[i].cyc - 1) step1();
            bus.clkLocked = vecs[i].lock;
            step1();
            check($sformatf("%s@%0d rstStageN", tag, cur), 32'(bus.rstStageN), 32'(vecs[i].stg));
            check($sformatf("%s@%0d ready", tag, cur), 32'(bus.ready), 32'(vecs[i].rdy));
            check($sformatf("%s@%0d lockLost", tag, cur), 32'(bus.lockLost), 32'(vecs[i].lost));
            check($sformatf("%s@%0d count", tag, cur), 32'(bus.lockLossCount), 32'(exp_cnt(vecs[i].cnt)));
        end
        vecs.delete();
    endtask

    task automatic do_reset(input string tag);
        rstN = 1'b0;
        bus.clkLocked = 1'b0;
        repeat (3) step1();
        check({tag, " reset rstStageN"}, 32'(bus.rstStageN), 32'd0);
        check({tag, " reset ready"}, 32'(bus.ready), 32'd0);
        check({tag, " reset lockLost"}, 32'(bus.lockLost), 32'd0);
        check({tag, " reset count"}, 32'(bus.lockLossCount), 32'd0);
        rstN = 1'b1;
        cur = -1;
    endtask

    initial begin
        int k;
        tests = 0;
        fails = 0;
        cur = -1;
        rstN = 1'b0;
        bus.clkLocked = 1'b0;

        // Power-up schedule, then loss in RUN at 40 and a re-rise at 50.
        do_reset("pwr");
        add(0,  1, 3'b000, 0, 0, 0);
        add(9,  1, 3'b000, 0, 0, 0);
        add(10, 1, 3'b001, 0, 0, 0);
        add(13, 1, 3'b001, 0, 0, 0);
        add(14, 1, 3'b011, 0, 0, 0);
        add(17, 1, 3'b011, 0, 0, 0);
        add(18, 1, 3'b111, 0, 0, 0);
        add(21, 1, 3'b111, 0, 0, 0);
        add(22, 1, 3'b111, 1, 0, 0);
        add(39, 1, 3'b111, 1, 0, 0);
        add(40, 0, 3'b111, 1, 0, 0);
        add(42, 0, 3'b111, 1, 0, 0);
        add(43, 0, 3'b000, 0, 1, 1);
        add(44, 0, 3'b000, 0, 0, 1);
        add(50, 1, 3'b000, 0, 0, 1);
        add(59, 1, 3'b000, 0, 0, 1);
        add(60, 1, 3'b001, 0, 0, 1);
        add(64, 1, 3'b011, 0, 0, 1);
        add(68, 1, 3'b111, 0, 0, 1);
        add(71, 1, 3'b111, 0, 0, 1);
        add(72, 1, 3'b111, 1, 0, 1);
        run_vecs("run");

        // rstN in RUN wins over a high lock; the synchronizer is cleared too,
        // so the restarted schedule is the full power-up one.
        rstN = 1'b0;
        step1();
        check("rstN-in-RUN rstStageN", 32'(bus.rstStageN), 32'd0);
        check("rstN-in-RUN ready", 32'(bus.ready), 32'd0);
        check("rstN-in-RUN lockLost", 32'(bus.lockLost), 32'd0);
        check("rstN-in-RUN count", 32'(bus.lockLossCount), 32'd0);
        rstN = 1'b1;
        cur = -1;
        add(0,  1, 3'b000, 0, 0, 0);
        add(9,  1, 3'b000, 0, 0, 0);
        add(10, 1, 3'b001, 0, 0, 0);
        run_vecs("rst-restart");

        // Flaky lock while still in STABLE: no loss, schedule restarts at 6.
        do_reset("flaky");
        add(0,  1, 3'b000, 0, 0, 0);
        add(5,  0, 3'b000, 0, 0, 0);
        add(6,  1, 3'b000, 0, 0, 0);
        add(7,  1, 3'b000, 0, 0, 0);
        add(8,  1, 3'b000, 0, 0, 0);
        add(10, 1, 3'b000, 0, 0, 0);
        add(15, 1, 3'b000, 0, 0, 0);
        add(16, 1, 3'b001, 0, 0, 0);
        add(20, 1, 3'b011, 0, 0, 0);
        add(24, 1, 3'b111, 0, 0, 0);
        add(27, 1, 3'b111, 0, 0, 0);
        add(28, 1, 3'b111, 1, 0, 0);
        run_vecs("flaky");

        // Drop one cycle after bit 1 releases: the loss lands on the edge
        // where bit 2 was due, and bit 2 must stay asserted.
        do_reset("midrel");
        add(0,  1, 3'b000, 0, 0, 0);
        add(14, 1, 3'b011, 0, 0, 0);
        add(15, 0, 3'b011, 0, 0, 0);
        add(17, 0, 3'b011, 0, 0, 0);
        add(18, 0, 3'b000, 0, 1, 1);
        add(19, 0, 3'b000, 0, 0, 1);
        add(30, 0, 3'b000, 0, 0, 1);
        run_vecs("midrel");

        // Saturation: 260 losses from RUN.
        do_reset("sat");
        for (int n = 1; n <= 260; n++) begin
            bus.clkLocked = 1'b1;
            k = 0;
            while (bus.ready !== 1'b1 && k < 60) begin step1(); k++; end
            if (bus.ready !== 1'b1) begin
                tests++;
                fails++;
                $display("FAIL sat ready timeout loss %0d: got ready=%b, required 1", n, bus.ready);
                break;
            end
            bus.clkLocked = 1'b0;
            k = 0;
            while (bus.lockLost !== 1'b1 && k < 10) begin step1(); k++; end
            if (bus.lockLost !== 1'b1) begin
                tests++;
                fails++;
                $display("FAIL sat lockLost timeout loss %0d: got lockLost=%b, required 1", n, bus.lockLost);
                break;
            end
            if (n == 1 || n == 254 || n == 255 || n == 256 || n == 260) begin
                check($sformatf("sat count after %0d losses", n),
                      32'(bus.lockLossCount), 32'(exp_cnt(n)));
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
